// File: rtl/systolic_mac_pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
package systolic_mac_pe_pkg;

  localparam int unsigned MAX_ACC_W = 128;

  typedef enum logic [0:0] {
    PE_INIT,
    PE_RUN
  } pe_state_e;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [MAX_ACC_W-1:0] sat_to_width(
    input logic signed [MAX_ACC_W-1:0] value,
    input int unsigned                 width
  );
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    lo = '1;
    lo = lo << (width - 1);
    hi = ~lo;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/systolic_mac_pe_if.sv
// Stream, read-out and status bundle of one systolic MAC PE.
interface systolic_mac_pe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [ADDR_W-1:0] in_addr;
  logic              in_first;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [ADDR_W-1:0] out_addr;
  logic              out_first;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [ACC_W-1:0]  rd_data;
  logic              sat_flag;
  logic              clr_sat;
  logic              busy;

  modport slave (
    input  in_valid, in_a, in_b, in_addr, in_first, out_ready, rd_req, rd_addr, clr_sat,
    output in_ready, out_valid, out_a, out_b, out_addr, out_first, rd_valid, rd_data,
           sat_flag, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_addr, in_first, out_ready, rd_req, rd_addr, clr_sat,
    input  in_ready, out_valid, out_a, out_b, out_addr, out_first, rd_valid, rd_data,
           sat_flag, busy
  );
endinterface

// File: rtl/pe_acc_file.sv
// Accumulator register file: async read for the MAC stage, sync write,
// and a registered read-out port that sees same-cycle writes.
module pe_acc_file #(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ACC_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ACC_W-1:0]  rd_data,
  input  logic              ro_req,
  input  logic [ADDR_W-1:0] ro_addr,
  output logic              ro_valid,
  output logic [ACC_W-1:0]  ro_data
);
  logic [ACC_W-1:0] mem [DEPTH];

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ro_valid <= 1'b0;
      ro_data  <= '0;
    end else begin
      ro_valid <= ro_req;
      if (ro_req) begin
        ro_data <= (wr_en && (wr_addr == ro_addr)) ? wr_data : mem[ro_addr];
      end
    end
  end
endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC PE: forwards operand pairs downstream and accumulates their
// signed products into a local accumulator file via a 2-stage pipeline.
module systolic_mac_pe
  import systolic_mac_pe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned SAT_EN = 1
) (
  input logic              clk,
  input logic              rst,
  systolic_mac_pe_if.slave pe
);
  localparam int unsigned PROD_W = 2 * DATA_W;

  pe_state_e                state;
  logic [ADDR_W-1:0]        init_cnt;
  logic                     run;
  logic                     accept;

  logic                     s1_valid;
  logic signed [PROD_W-1:0] s1_prod;
  logic [ADDR_W-1:0]        s1_addr;
  logic                     s1_first;
  logic                     s2_valid;
  logic signed [PROD_W-1:0] s2_prod;
  logic [ADDR_W-1:0]        s2_addr;
  logic                     s2_first;

  logic [ACC_W-1:0]         acc_rd;
  logic [ACC_W-1:0]         acc_base;
  logic signed [ACC_W:0]    sum;
  logic                     ovf;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [ACC_W-1:0]         wr_data;

  assign run         = (state == PE_RUN);
  assign pe.in_ready = !rst && run && (!pe.out_valid || pe.out_ready);
  assign accept      = pe.in_valid && pe.in_ready;
  assign pe.busy     = !rst && (s1_valid || s2_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PE_INIT;
      init_cnt     <= '0;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      pe.out_valid <= 1'b0;
      pe.out_a     <= '0;
      pe.out_b     <= '0;
      pe.out_addr  <= '0;
      pe.out_first <= 1'b0;
      pe.sat_flag  <= 1'b0;
    end else begin
      if (state == PE_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == ADDR_W'(DEPTH - 1)) state <= PE_RUN;
      end
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        pe.out_valid <= 1'b1;
        pe.out_a     <= pe.in_a;
        pe.out_b     <= pe.in_b;
        pe.out_addr  <= pe.in_addr;
        pe.out_first <= pe.in_first;
      end else if (pe.out_ready) begin
        pe.out_valid <= 1'b0;
      end
      // A same-cycle overflow beats the clear.
      if (s2_valid && ovf) pe.sat_flag <= 1'b1;
      else if (pe.clr_sat) pe.sat_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_prod  <= $signed(pe.in_a) * $signed(pe.in_b);
      s1_addr  <= pe.in_addr;
      s1_first <= pe.in_first;
    end
    s2_prod  <= s1_prod;
    s2_addr  <= s1_addr;
    s2_first <= s1_first;
  end

  // S2 reads the file combinationally, so a write at the end of the previous
  // cycle is already visible to the next pair for the same entry.
  assign acc_base = s2_first ? '0 : acc_rd;
  assign sum      = $signed({acc_base[ACC_W-1], acc_base}) + (ACC_W + 1)'(s2_prod);
  assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_cnt;
    wr_data = '0;
    if (state == PE_INIT) begin
      wr_en = 1'b1;
    end else if (s2_valid) begin
      wr_en   = 1'b1;
      wr_addr = s2_addr;
      if ((SAT_EN != 0) && ovf) wr_data = ACC_W'(sat_to_width(MAX_ACC_W'(sum), ACC_W));
      else                      wr_data = sum[ACC_W-1:0];
    end
  end

  pe_acc_file #(
    .ACC_W  (ACC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_acc_file (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (s2_addr),
    .rd_data  (acc_rd),
    .ro_req   (pe.rd_req && run),
    .ro_addr  (pe.rd_addr),
    .ro_valid (pe.rd_valid),
    .ro_data  (pe.rd_data)
  );
endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
- Parametrised integer multiply-accumulate processing element for the systolic matrix-multiply array.
- Accepts operand pairs (a, b) with a target accumulator address over a valid/ready stream.
- Forwards each accepted pair unchanged to the next PE in the chain.
- Accumulates signed products into a DEPTH-entry local accumulator file through a fixed 2-stage pipeline; adds a first-term clear, optional saturation, and an independent read-out port.

Parameters:
- DATA_W, 16: signed operand width for a and b.
- ACC_W, 40: signed accumulator width; must be >= 2*DATA_W.
- DEPTH, 8: number of accumulator entries; must be >= 2.
- ADDR_W, $clog2(DEPTH): accumulator address width.
- SAT_EN, 1: 1 = saturate on accumulator overflow; 0 = two's-complement wrap.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  PE can accept a pair this cycle.
- in_a  input  DATA_W  signed operand a.
- in_b  input  DATA_W  signed operand b.
- in_addr  input  ADDR_W  target accumulator entry.
- in_first  input  1  1 = overwrite the entry with the product instead of adding to it.
- out_valid  output  1  forwarded pair valid to the next PE.
- out_ready  input  1  next PE accepts the forwarded pair.
- out_a  output  DATA_W  forwarded a.
- out_b  output  DATA_W  forwarded b.
- out_addr  output  ADDR_W  forwarded addr.
- out_first  output  1  forwarded first flag.
- rd_req  input  1  read-out request.
- rd_addr  input  ADDR_W  read-out entry.
- rd_valid  output  1  read data valid (single-cycle pulse).
- rd_data  output  ACC_W  accumulator value.
- sat_flag  output  1  sticky overflow indicator.
- clr_sat  input  1  clears sat_flag.
- busy  output  1  a multiply-accumulate is still in the pipeline.

Behaviour:
- Reset, while rst is high:
  - Outputs in_ready, out_valid, rd_valid, sat_flag and busy are 0.
  - out_a, out_b, out_addr, out_first and rd_data are 0.
  - All pipeline valid bits are cleared and the state goes to INIT.
  - rst asserted mid-operation discards all in-flight work and restarts INIT.
- State INIT:
  - An internal counter writes 0 to entry 0..DEPTH-1, one entry per cycle.
  - After exactly DEPTH cycles following rst deassertion, the state moves to RUN.
  - in_ready is 0 throughout INIT.
  - rd_req is ignored during INIT: no rd_valid pulse.
- State RUN: stays in RUN until rst.
- Accept handshake:
  - in_ready = RUN && (!out_valid || out_ready).
  - A pair is accepted when in_valid && in_ready.
- Forward path:
  - On accept, the out_* registers load in_a, in_b, in_addr and in_first, and out_valid goes to 1.
  - Otherwise, if out_ready is high, out_valid goes to 0.
  - out_* must hold stable while out_valid && !out_ready.
- Stage S1 (cycle after accept): product register = in_a * in_b, full 2*DATA_W signed; addr and first travel with it.
- Stage S2 (next cycle):
  - sum = (first ? 0 : mem[addr]) + sign-extended product, computed at ACC_W+1 bits.
  - Overflow occurs when sum is outside the signed ACC_W range.
  - SAT_EN=1: overflow writes +max or -min accordingly. SAT_EN=0: the low ACC_W bits are written.
  - Overflow sets sat_flag in either mode.
  - The write happens at the end of S2.
- Pipeline timing and hazards:
  - Accept-to-write latency is 2 cycles. S1 and S2 never stall; throughput is 1 pair per cycle.
  - The accumulator file is read combinationally in S2, so back-to-back pairs to the same addr accumulate correctly without forwarding logic.
- Read-out port:
  - rd_req in RUN produces rd_valid=1 on the next cycle, with rd_data = the entry value after any S2 write in the request cycle (write-first bypass).
  - Back-to-back rd_req is allowed; rd_data holds its value when rd_valid is 0.
  - Read-out is independent of the stream handshake.
- sat_flag:
  - Sticky; cleared by clr_sat or rst.
  - If an overflow and clr_sat occur in the same cycle, the overflow wins and sat_flag stays 1.
- busy = S1 valid || S2 valid.

Decomposition:
- Shared package: PE state encoding (INIT, RUN) and a saturate-to-width function; reuse the package's existing index/size constants.
- One natural sub-module, pe_acc_file: a DEPTH x ACC_W register file with one combinational read, one synchronous write, and the registered bypassed read-out port.

Test Plan:
- Init: rst for 2 cycles with DEPTH=8 -> in_ready stays 0 for exactly 8 cycles, then 1; rd_req on addr 0..7 -> rd_data 0 for all entries.
- Basic MAC: (3,4,addr=2,first=1) then (-5,6,addr=2,first=0) -> busy falls after 2 cycles; rd addr 2 -> -18; out_* shows each pair one cycle after its accept.
- Hazard: four consecutive cycles of (1,1,addr=5) with first=1 on the first pair -> rd addr 5 = 4; rd_req in the same cycle as the final S2 write -> 4 (bypass).
- Backpressure: out_ready=0 while out_valid=1 -> in_ready=0, no accept, out_a held; out_ready=1 -> exactly one transfer, then accepts resume.
- Saturation: ACC_W=32, SAT_EN=1, three pairs (32767,32767,addr=0) -> entry = 2147483647 and sat_flag=1; clr_sat -> 0. Same run with SAT_EN=0 -> wrapped value -1073938429.
- Reset mid-operation: rst while S1 and S2 are valid -> busy=0 and out_valid=0; after 8 INIT cycles all entries read 0.
